// File: rtl/packed_array_packer.sv
// ============================================================================
// packed_array_packer: gathers WB-bit elements into a [WA-1:0][WB-1:0] word
// Revision: 1.0
// ============================================================================
`default_nettype none

module packed_array_packer #(
  parameter int              WA     = 8,
  parameter int              WB     = 8,
  parameter int              LITTLE = 0,
  parameter logic [WB-1:0]   PAD    = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_vld,
  output logic                          in_rdy,
  input  logic [WB-1:0]                 in_dat,
  input  logic                          in_lst,
  output logic                          out_vld,
  input  logic                          out_rdy,
  output logic [WA-1:0][WB-1:0]         out_dat,
  output logic [$clog2(WA+1)-1:0]       out_cnt,
  output logic                          out_lst
);

  localparam int             CW       = (WA > 1) ? $clog2(WA) : 1;
  localparam int             OCW      = $clog2(WA + 1);
  localparam logic [CW-1:0]  LAST_IDX = CW'(WA - 1);

  generate
    if (WA < 2 || WB < 1) begin : g_param_check
      $fatal(1, "packed_array_packer: WA must be >= 2 and WB >= 1");
    end
  endgenerate

  logic [CW-1:0]            cnt_q, cnt_d;
  logic [WA-1:0][WB-1:0]    acc_q, acc_d;
  logic [WA-1:0][WB-1:0]    merged;
  logic [WA-1:0][WB-1:0]    out_dat_q, out_dat_d;
  logic [OCW-1:0]           out_cnt_q, out_cnt_d;
  logic                     out_vld_q, out_vld_d;
  logic                     out_lst_q, out_lst_d;

  logic                     accept;
  logic                     last_slot;
  logic                     close;
  logic [CW-1:0]            idx;

  assign in_rdy    = !out_vld_q || out_rdy;
  assign accept    = in_vld && in_rdy;
  assign last_slot = (cnt_q == LAST_IDX);
  assign close     = accept && (last_slot || in_lst);
  // Descending fill mirrors the element position around the word.
  assign idx       = (LITTLE != 0) ? (LAST_IDX - cnt_q) : cnt_q;

  always_comb begin
    merged      = acc_q;
    merged[idx] = in_dat;

    cnt_d     = cnt_q;
    acc_d     = acc_q;
    out_dat_d = out_dat_q;
    out_cnt_d = out_cnt_q;
    out_vld_d = out_vld_q;
    out_lst_d = out_lst_q;

    if (out_vld_q && out_rdy) begin
      out_vld_d = 1'b0;
    end

    if (close) begin
      out_dat_d = merged;
      out_cnt_d = OCW'(cnt_q) + OCW'(1);
      out_vld_d = 1'b1;
      out_lst_d = in_lst && !last_slot;
      cnt_d     = '0;
      acc_d     = {WA{PAD}};
    end else if (accept) begin
      acc_d = merged;
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      acc_q     <= {WA{PAD}};
      out_dat_q <= '0;
      out_cnt_q <= '0;
      out_vld_q <= 1'b0;
      out_lst_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      out_dat_q <= out_dat_d;
      out_cnt_q <= out_cnt_d;
      out_vld_q <= out_vld_d;
      out_lst_q <= out_lst_d;
    end
  end

  assign out_vld = out_vld_q;
  assign out_dat = out_dat_q;
  assign out_cnt = out_cnt_q;
  assign out_lst = out_lst_q;

endmodule

`default_nettype wire

// File: tb/tb_packed_array_packer.sv
// ============================================================================
// tb_packed_array_packer: three packer variants driven by one stream, checked
// against a queue-level model plus hand-computed words.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_packed_array_packer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_vld = 1'b0;
  logic [7:0] in_dat = 8'h00;
  logic       in_lst = 1'b0;
  logic       out_rdy = 1'b1;

  logic             in_rdy0, in_rdy1, in_rdy2;
  logic             out_vld0, out_vld1, out_vld2;
  logic [3:0][7:0]  out_dat0, out_dat1, out_dat2;
  logic [2:0]       out_cnt0, out_cnt1, out_cnt2;
  logic             out_lst0, out_lst1, out_lst2;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  packed_array_packer #(.WA(4), .WB(8), .LITTLE(0), .PAD(8'h00)) u_asc (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy0), .in_dat(in_dat),
    .in_lst(in_lst), .out_vld(out_vld0), .out_rdy(out_rdy), .out_dat(out_dat0),
    .out_cnt(out_cnt0), .out_lst(out_lst0));

  packed_array_packer #(.WA(4), .WB(8), .LITTLE(1), .PAD(8'h00)) u_desc (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy1), .in_dat(in_dat),
    .in_lst(in_lst), .out_vld(out_vld1), .out_rdy(out_rdy), .out_dat(out_dat1),
    .out_cnt(out_cnt1), .out_lst(out_lst1));

  packed_array_packer #(.WA(4), .WB(8), .LITTLE(0), .PAD(8'hEE)) u_pad (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy2), .in_dat(in_dat),
    .in_lst(in_lst), .out_vld(out_vld2), .out_rdy(out_rdy), .out_dat(out_dat2),
    .out_cnt(out_cnt2), .out_lst(out_lst2));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Element k of a group of n lands at k (ascending) or 3-k (descending).
  function automatic logic [31:0] build(input logic [7:0] e [4], input int n,
                                        input bit little, input logic [7:0] pad);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      int pos;
      pos = little ? 3 - k : k;
      w[pos*8 +: 8] = (k < n) ? e[k] : pad;
    end
    return w;
  endfunction

  // Model of what the packed output must show after each edge.
  logic [7:0]  grp [4];
  int          m_n;
  logic        m_vld, m_lst;
  logic [31:0] m_d0, m_d1, m_d2;
  int          m_cnt;

  always @(posedge clk or negedge rst_n) begin : model
    logic [7:0] tmp [4];
    bit         mrdy;
    if (!rst_n) begin
      m_vld <= 1'b0; m_lst <= 1'b0; m_n <= 0; m_cnt <= 0;
      m_d0 <= '0; m_d1 <= '0; m_d2 <= '0;
    end else begin
      mrdy = !m_vld || out_rdy;
      if (m_vld && out_rdy) m_vld <= 1'b0;
      if (in_vld && mrdy) begin
        tmp = grp;
        tmp[m_n] = in_dat;
        if (m_n == 3 || in_lst) begin
          m_vld <= 1'b1;
          m_d0  <= build(tmp, m_n + 1, 1'b0, 8'h00);
          m_d1  <= build(tmp, m_n + 1, 1'b1, 8'h00);
          m_d2  <= build(tmp, m_n + 1, 1'b0, 8'hEE);
          m_cnt <= m_n + 1;
          m_lst <= (m_n < 3);
          m_n   <= 0;
        end else begin
          grp[m_n] <= in_dat;
          m_n      <= m_n + 1;
        end
      end
    end
  end

  always begin : compare
    @(negedge clk);
    #2;
    if (rst_n) begin
      chk("in_rdy_asc",  64'(in_rdy0), 64'(!m_vld || out_rdy));
      chk("in_rdy_desc", 64'(in_rdy1), 64'(!m_vld || out_rdy));
      chk("in_rdy_pad",  64'(in_rdy2), 64'(!m_vld || out_rdy));
      chk("vld_asc",  64'(out_vld0), 64'(m_vld));
      chk("vld_desc", 64'(out_vld1), 64'(m_vld));
      chk("vld_pad",  64'(out_vld2), 64'(m_vld));
      if (m_vld) begin
        chk("dat_asc",  64'(out_dat0), 64'(m_d0));
        chk("dat_desc", 64'(out_dat1), 64'(m_d1));
        chk("dat_pad",  64'(out_dat2), 64'(m_d2));
        chk("cnt_asc",  64'(out_cnt0), 64'(m_cnt));
        chk("cnt_desc", 64'(out_cnt1), 64'(m_cnt));
        chk("lst_asc",  64'(out_lst0), 64'(m_lst));
        chk("lst_pad",  64'(out_lst2), 64'(m_lst));
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic l);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      in_vld = 1'b1; in_dat = d; in_lst = l;
      #1;
      done = in_rdy0;
      @(posedge clk);
    end
    if (!done) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_vld = 1'b0; in_lst = 1'b0;
    end
  endtask

  task automatic check_word(input string nm, input logic [31:0] e0, input logic [31:0] e1,
                            input logic [31:0] e2, input int c, input logic l);
    @(negedge clk);
    in_vld = 1'b0; in_lst = 1'b0;
    #1;
    chk({nm, "_vld"},  64'(out_vld0), 64'd1);
    chk({nm, "_asc"},  64'(out_dat0), 64'(e0));
    chk({nm, "_desc"}, 64'(out_dat1), 64'(e1));
    chk({nm, "_pad"},  64'(out_dat2), 64'(e2));
    chk({nm, "_cnt"},  64'(out_cnt0), 64'(c));
    chk({nm, "_lst"},  64'(out_lst0), 64'(l));
  endtask

  initial begin
    bit last_acc;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_vld", 64'(out_vld0), 64'd0);
    chk("rst_dat", 64'(out_dat0), 64'd0);
    chk("rst_cnt", 64'(out_cnt0), 64'd0);
    chk("rst_lst", 64'(out_lst0), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // full word, both fill orders
    out_rdy = 1'b1;
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
    check_word("full", 32'h44332211, 32'h11223344, 32'h44332211, 4, 1'b0);

    // short group then full group
    idle(2);
    send(8'hAA, 0); send(8'hBB, 1);
    check_word("short", 32'h0000BBAA, 32'hAABB0000, 32'hEEEEBBAA, 2, 1'b1);
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
    check_word("after_short", 32'h04030201, 32'h01020304, 32'h04030201, 4, 1'b0);

    // backpressure hold, then drain and close on the same edge
    idle(2);
    out_rdy = 1'b0;
    send(8'h10, 0); send(8'h11, 0); send(8'h12, 0); send(8'h13, 0);
    check_word("held", 32'h13121110, 32'h10111213, 32'h13121110, 4, 1'b0);
    repeat (5) begin
      @(negedge clk);
      #1;
      chk("hold_in_rdy", 64'(in_rdy0), 64'd0);
      chk("hold_dat",    64'(out_dat0), 64'h13121110);
    end
    @(negedge clk);
    out_rdy = 1'b1; in_vld = 1'b1; in_dat = 8'h77; in_lst = 1'b1;
    #1;
    chk("nobubble_in_rdy", 64'(in_rdy0), 64'd1);
    @(posedge clk);
    check_word("nobubble", 32'h00000077, 32'h77000000, 32'hEEEEEE77, 1, 1'b1);

    // single-element group
    idle(2);
    send(8'h5A, 1);
    check_word("single", 32'h0000005A, 32'h5A000000, 32'hEEEEEE5A, 1, 1'b1);

    // reset mid-group discards partial data
    idle(2);
    send(8'h01, 0); send(8'h02, 0);
    @(negedge clk);
    in_vld = 1'b0; rst_n = 1'b0;
    #1;
    chk("midrst_vld", 64'(out_vld0), 64'd0);
    chk("midrst_dat", 64'(out_dat0), 64'd0);
    chk("midrst_cnt", 64'(out_cnt0), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h55, 0); send(8'h66, 0); send(8'h77, 0); send(8'h88, 0);
    check_word("post_rst", 32'h88776655, 32'h55667788, 32'h88776655, 4, 1'b0);

    // random traffic, producer holds data until accepted
    last_acc = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      out_rdy = ($urandom_range(3) != 0);
      if (!in_vld || last_acc) begin
        in_vld = ($urandom_range(3) != 0);
        in_dat = 8'($urandom);
        in_lst = ($urandom_range(4) == 0);
      end
      #1;
      last_acc = in_vld && in_rdy0;
    end
    @(negedge clk);
    in_vld = 1'b0; out_rdy = 1'b1;
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
